// File: rtl/mem_ctrl_pkg.sv
// mem_ctrl_pkg: shared types and constants for the byte-enable command/data memory.
//   rsp_state_e : response-stage occupancy (EMPTY / FULL)
//   err_cause_e : why a request was rejected (also handy for benches)
//   be_width()  : byte-enable width for a given data width
package mem_ctrl_pkg;

    typedef enum logic [0:0] {
        RSP_EMPTY,
        RSP_FULL
    } rsp_state_e;

    typedef enum logic [1:0] {
        ERR_NONE,
        ERR_RANGE,
        ERR_LOCK
    } err_cause_e;

    localparam int unsigned DATA_W_DEFAULT = 32;
    localparam int unsigned BE_W           = DATA_W_DEFAULT / 8;

    function automatic int unsigned be_width(input int unsigned data_w);
        return data_w / 8;
    endfunction

endpackage

// File: rtl/mem_be_array.sv
// mem_be_array: word-addressed storage with per-byte write enables.
// The lowest CMD_DEPTH words are cleared by the synchronous reset; the
// remaining words have no reset and keep their contents across it.
// Ports:
//   clk, rst_n : clock, synchronous active-low reset
//   we         : write strobe (already qualified by the caller)
//   waddr      : write word address
//   wdata, wbe : write data and byte enables
//   raddr      : read word address (combinational read)
//   rdata      : read data; 0 when raddr is beyond DEPTH
module mem_be_array
    import mem_ctrl_pkg::*;
#(
    parameter int unsigned DATA_W    = 32,
    parameter int unsigned DEPTH     = 16,
    parameter int unsigned ADDR_W    = 4,
    parameter int unsigned CMD_DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  we,
    input  logic [ADDR_W-1:0]     waddr,
    input  logic [DATA_W-1:0]     wdata,
    input  logic [DATA_W/8-1:0]   wbe,
    input  logic [ADDR_W-1:0]     raddr,
    output logic [DATA_W-1:0]     rdata
);

    localparam int unsigned BW = be_width(DATA_W);

    logic [DATA_W-1:0] words [DEPTH];

    for (genvar w = 0; w < DEPTH; w++) begin : g_word
        logic [DATA_W-1:0] word_q;
        logic              hit;

        assign hit      = we && (waddr == ADDR_W'(w));
        assign words[w] = word_q;

        if (w < CMD_DEPTH) begin : g_cmd
            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    word_q <= '0;
                end else if (hit) begin
                    for (int b = 0; b < BW; b++) begin
                        if (wbe[b]) word_q[8*b +: 8] <= wdata[8*b +: 8];
                    end
                end
            end
        end else begin : g_data
            // Data words deliberately have no reset.
            always_ff @(posedge clk) begin
                if (hit) begin
                    for (int b = 0; b < BW; b++) begin
                        if (wbe[b]) word_q[8*b +: 8] <= wdata[8*b +: 8];
                    end
                end
            end
        end
    end

    assign rdata = (32'(raddr) < DEPTH) ? words[raddr] : '0;

endmodule

// File: rtl/mem_ctrl_be.sv
// mem_ctrl_be: parametrised command/data memory with byte enables, a
// valid/ready request/response handshake, a lockable command region and
// out-of-range error reporting. One response per accepted request, one
// cycle after acceptance; the response register holds under backpressure.
// Ports:
//   clk, rst_n                      : clock, synchronous active-low reset
//   req_valid/req_ready             : request handshake
//   req_wr, req_addr, req_wdata, req_be : request fields (sampled on accept)
//   cmd_lock                        : write-protect words 0..CMD_DEPTH-1
//   rsp_valid/rsp_ready             : response handshake
//   rsp_wr, rsp_rdata, rsp_err      : response fields
module mem_ctrl_be
    import mem_ctrl_pkg::*;
#(
    parameter int unsigned DATA_W    = 32,
    parameter int unsigned DEPTH     = 16,
    parameter int unsigned ADDR_W    = 4,
    parameter int unsigned CMD_DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_wr,
    input  logic [ADDR_W-1:0]     req_addr,
    input  logic [DATA_W-1:0]     req_wdata,
    input  logic [DATA_W/8-1:0]   req_be,
    input  logic                  cmd_lock,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic                  rsp_wr,
    output logic [DATA_W-1:0]     rsp_rdata,
    output logic                  rsp_err
);

    rsp_state_e        state_q, state_d;
    logic              rsp_wr_q, rsp_wr_d;
    logic              rsp_err_q, rsp_err_d;
    logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;

    logic              accept;
    err_cause_e        err_cause;
    logic              req_err;
    logic              mem_we;
    logic [DATA_W-1:0] mem_rdata;

    // Request side
    assign req_ready = rst_n && ((state_q == RSP_EMPTY) || rsp_ready);
    assign accept    = req_valid && req_ready;

    always_comb begin
        err_cause = ERR_NONE;
        if (32'(req_addr) >= DEPTH) begin
            err_cause = ERR_RANGE;
        end else if (req_wr && cmd_lock && (32'(req_addr) < CMD_DEPTH)) begin
            err_cause = ERR_LOCK;
        end
    end

    assign req_err = (err_cause != ERR_NONE);
    assign mem_we  = accept && req_wr && !req_err;

    mem_be_array #(
        .DATA_W    (DATA_W),
        .DEPTH     (DEPTH),
        .ADDR_W    (ADDR_W),
        .CMD_DEPTH (CMD_DEPTH)
    ) u_array (
        .clk   (clk),
        .rst_n (rst_n),
        .we    (mem_we),
        .waddr (req_addr),
        .wdata (req_wdata),
        .wbe   (req_be),
        .raddr (req_addr),
        .rdata (mem_rdata)
    );

    // Response stage: next state and payload
    always_comb begin
        state_d     = state_q;
        rsp_wr_d    = rsp_wr_q;
        rsp_err_d   = rsp_err_q;
        rsp_rdata_d = rsp_rdata_q;

        unique case (state_q)
            RSP_EMPTY: begin
                if (accept) state_d = RSP_FULL;
            end
            RSP_FULL: begin
                // Accept while full implies rsp_ready: the slot is replaced.
                if (accept)         state_d = RSP_FULL;
                else if (rsp_ready) state_d = RSP_EMPTY;
            end
            default: state_d = RSP_EMPTY;
        endcase

        if (accept) begin
            rsp_wr_d    = req_wr;
            rsp_err_d   = req_err;
            // Read sees the array before this edge, which already holds any
            // write accepted on an earlier edge.
            rsp_rdata_d = (!req_wr && !req_err) ? mem_rdata : '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= RSP_EMPTY;
            rsp_wr_q    <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_rdata_q <= '0;
        end else begin
            state_q     <= state_d;
            rsp_wr_q    <= rsp_wr_d;
            rsp_err_q   <= rsp_err_d;
            rsp_rdata_q <= rsp_rdata_d;
        end
    end

    assign rsp_valid = (state_q == RSP_FULL);
    assign rsp_wr    = rsp_wr_q;
    assign rsp_err   = rsp_err_q;
    assign rsp_rdata = rsp_rdata_q;

endmodule

// File: tb/tb_mem_ctrl_be.sv
// tb_mem_ctrl_be: directed bench for mem_ctrl_be (DEPTH=12 so the range
// check is reachable with a 4-bit address).
module tb_mem_ctrl_be;

    localparam int unsigned DATA_W    = 32;
    localparam int unsigned DEPTH     = 12;
    localparam int unsigned ADDR_W    = 4;
    localparam int unsigned CMD_DEPTH = 4;

    logic              clk;
    logic              rst_n;
    logic              req_valid;
    logic              req_ready;
    logic              req_wr;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;
    logic [3:0]        req_be;
    logic              cmd_lock;
    logic              rsp_valid;
    logic              rsp_ready;
    logic              rsp_wr;
    logic [DATA_W-1:0] rsp_rdata;
    logic              rsp_err;

    int n_checks = 0;
    int n_errors = 0;

    mem_ctrl_be #(
        .DATA_W    (DATA_W),
        .DEPTH     (DEPTH),
        .ADDR_W    (ADDR_W),
        .CMD_DEPTH (CMD_DEPTH)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_wr    (req_wr),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .req_be    (req_be),
        .cmd_lock  (cmd_lock),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_wr    (rsp_wr),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Present one request for one edge, then sample #1 after that edge.
    task automatic do_req(input logic wr, input logic [ADDR_W-1:0] addr,
                          input logic [31:0] wdata, input logic [3:0] be);
        req_valid = 1'b1;
        req_wr    = wr;
        req_addr  = addr;
        req_wdata = wdata;
        req_be    = be;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
    endtask

    task automatic check_rsp(input string tag, input logic wr, input logic err,
                             input logic [31:0] rdata);
        check_eq({tag, ".valid"}, 32'(rsp_valid), 32'd1);
        check_eq({tag, ".wr"},    32'(rsp_wr),    32'(wr));
        check_eq({tag, ".err"},   32'(rsp_err),   32'(err));
        check_eq({tag, ".rdata"}, rsp_rdata,      rdata);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n     = 1'b0;
        req_valid = 1'b0;
        req_wr    = 1'b0;
        req_addr  = '0;
        req_wdata = '0;
        req_be    = '0;
        cmd_lock  = 1'b0;
        rsp_ready = 1'b1;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check_eq("rst.rsp_valid", 32'(rsp_valid), 32'd0);
        check_eq("rst.rsp_wr",    32'(rsp_wr),    32'd0);
        check_eq("rst.rsp_err",   32'(rsp_err),   32'd0);
        check_eq("rst.rsp_rdata", rsp_rdata,      32'h0);
        check_eq("rst.req_ready", 32'(req_ready), 32'd0);
        rst_n = 1'b1;
        #1;
        check_eq("post_rst.req_ready", 32'(req_ready), 32'd1);

        // Command region reads zero after reset
        do_req(1'b0, 4'd0, 32'h0, 4'h0);
        check_rsp("rd0", 1'b0, 1'b0, 32'h0000_0000);
        do_req(1'b0, 4'd3, 32'h0, 4'h0);
        check_rsp("rd3", 1'b0, 1'b0, 32'h0000_0000);

        // Byte-enable writes, back to back
        do_req(1'b1, 4'd5, 32'hAABB_CCDD, 4'b1111);
        check_rsp("wr5a", 1'b1, 1'b0, 32'h0);
        do_req(1'b1, 4'd5, 32'h1122_3344, 4'b0101);
        check_rsp("wr5b", 1'b1, 1'b0, 32'h0);
        do_req(1'b0, 4'd5, 32'h0, 4'h0);
        check_rsp("rd5", 1'b0, 1'b0, 32'hAA22_CC44);
        do_req(1'b1, 4'd5, 32'hFFFF_FFFF, 4'b0000);
        check_rsp("wr5_be0", 1'b1, 1'b0, 32'h0);
        do_req(1'b0, 4'd5, 32'h0, 4'h0);
        check_rsp("rd5_be0", 1'b0, 1'b0, 32'hAA22_CC44);

        // Lock protection
        cmd_lock = 1'b1;
        do_req(1'b1, 4'd2, 32'hDEAD_BEEF, 4'b1111);
        check_rsp("wr2_locked", 1'b1, 1'b1, 32'h0);
        do_req(1'b0, 4'd2, 32'h0, 4'h0);
        check_rsp("rd2_locked", 1'b0, 1'b0, 32'h0);
        cmd_lock = 1'b0;
        do_req(1'b1, 4'd2, 32'hDEAD_BEEF, 4'b1111);
        check_rsp("wr2_open", 1'b1, 1'b0, 32'h0);
        do_req(1'b0, 4'd2, 32'h0, 4'h0);
        check_rsp("rd2_open", 1'b0, 1'b0, 32'hDEAD_BEEF);

        // Out of range
        do_req(1'b0, 4'd12, 32'h0, 4'h0);
        check_rsp("rd12", 1'b0, 1'b1, 32'h0);
        do_req(1'b1, 4'd11, 32'h0BAD_F00D, 4'b1111);
        check_rsp("wr11", 1'b1, 1'b0, 32'h0);
        do_req(1'b1, 4'd15, 32'h7777_7777, 4'b1111);
        check_rsp("wr15", 1'b1, 1'b1, 32'h0);
        do_req(1'b0, 4'd11, 32'h0, 4'h0);
        check_rsp("rd11", 1'b0, 1'b0, 32'h0BAD_F00D);

        // Backpressure
        do_req(1'b1, 4'd6, 32'h1234_5678, 4'b1111);
        check_rsp("wr6", 1'b1, 1'b0, 32'h0);
        do_req(1'b0, 4'd6, 32'h0, 4'h0);
        rsp_ready = 1'b0;
        check_rsp("rd6", 1'b0, 1'b0, 32'h1234_5678);
        // A request offered while stalled must be ignored.
        req_valid = 1'b1;
        req_wr    = 1'b0;
        req_addr  = 4'd5;
        #1;
        for (int i = 0; i < 3; i++) begin
            check_eq("stall.req_ready", 32'(req_ready), 32'd0);
            @(posedge clk);
            #1;
            check_rsp("stall", 1'b0, 1'b0, 32'h1234_5678);
        end
        rsp_ready = 1'b1;
        #1;
        check_eq("unstall.req_ready", 32'(req_ready), 32'd1);
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        check_rsp("replaced", 1'b0, 1'b0, 32'hAA22_CC44);
        @(posedge clk);
        #1;
        check_eq("drain.rsp_valid", 32'(rsp_valid), 32'd0);

        // Reset with a response pending
        do_req(1'b1, 4'd1, 32'h0000_0055, 4'b1111);
        check_rsp("wr1", 1'b1, 1'b0, 32'h0);
        do_req(1'b1, 4'd8, 32'h0000_0055, 4'b1111);
        rsp_ready = 1'b0;
        check_rsp("wr8", 1'b1, 1'b0, 32'h0);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        check_eq("midrst.rsp_valid", 32'(rsp_valid), 32'd0);
        check_eq("midrst.req_ready", 32'(req_ready), 32'd0);
        rst_n     = 1'b1;
        rsp_ready = 1'b1;
        do_req(1'b0, 4'd1, 32'h0, 4'h0);
        check_rsp("rd1_after_rst", 1'b0, 1'b0, 32'h0);
        do_req(1'b0, 4'd8, 32'h0, 4'h0);
        check_rsp("rd8_after_rst", 1'b0, 1'b0, 32'h0000_0055);
        do_req(1'b0, 4'd2, 32'h0, 4'h0);
        check_rsp("rd2_after_rst", 1'b0, 1'b0, 32'h0);
        do_req(1'b0, 4'd11, 32'h0, 4'h0);
        check_rsp("rd11_after_rst", 1'b0, 1'b0, 32'h0BAD_F00D);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
